// File: rtl/layer_output_packer.sv
// Collects serial neuron outputs into one packed vector; outValid rises 1 cycle after the last element.
// Holds the vector (dataReady low) until outReady; flush abandons a partial fill.
module layer_output_packer #(
  parameter int dataWidth    = 8,
  parameter int numOutputs   = 10,
  parameter int addressWidth = $clog2(numOutputs)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [dataWidth-1:0]             dataIn,
  input  logic                             dataValid,
  output logic                             dataReady,
  input  logic                             flush,
  input  logic                             outReady,
  output logic [dataWidth*numOutputs-1:0]  dataOut,
  output logic                             outValid,
  output logic [addressWidth-1:0]          writeIndex
);

  typedef enum logic {FILL, FULL} state_t;

  localparam logic [addressWidth-1:0] lastIndex = addressWidth'(numOutputs - 1);

  state_t state;

  assign dataReady = (state == FILL) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      writeIndex <= '0;
      outValid   <= 1'b0;
      dataOut    <= '0;
    end else if (state == FILL) begin
      if (flush) begin
        writeIndex <= '0;
      end else if (dataValid) begin
        // Decoded per-slot write keeps indices past numOutputs-1 from touching anything.
        for (int k = 0; k < numOutputs; k++) begin
          if (writeIndex == addressWidth'(k))
            dataOut[k*dataWidth +: dataWidth] <= dataIn;
        end
        if (writeIndex >= lastIndex) begin
          writeIndex <= '0;
          state      <= FULL;
          outValid   <= 1'b1;
        end else begin
          writeIndex <= writeIndex + addressWidth'(1);
        end
      end
    end else begin
      if (outReady) begin
        state    <= FILL;
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_layer_output_packer.sv
// Bench for layer_output_packer: reference model pushes completed vectors to a scoreboard queue.
module tb_layer_output_packer;
  localparam int DW = 8;
  localparam int N  = 10;
  localparam int AW = $clog2(N);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [DW-1:0]   dataIn = '0;
  logic            dataValid = 1'b0;
  logic            dataReady;
  logic            flush = 1'b0;
  logic            outReady = 1'b0;
  logic [DW*N-1:0] dataOut;
  logic            outValid;
  logic [AW-1:0]   writeIndex;

  int passed = 0;
  int total  = 0;

  logic [DW*N-1:0] model = '0;
  int              exp_idx = 0;
  bit              exp_full = 1'b0;
  logic [DW*N-1:0] sb[$];
  logic [DW*N-1:0] v;

  layer_output_packer #(.dataWidth(DW), .numOutputs(N)) dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .dataValid(dataValid),
    .dataReady(dataReady), .flush(flush), .outReady(outReady),
    .dataOut(dataOut), .outValid(outValid), .writeIndex(writeIndex)
  );

  always #5 clk = ~clk;

  // Advance one clock; the model consumes the inputs presented for that edge.
  task automatic tick();
    if (reset) begin
      model = '0; exp_idx = 0; exp_full = 1'b0;
    end else if (!exp_full) begin
      if (flush) exp_idx = 0;
      else if (dataValid) begin
        model[exp_idx*DW +: DW] = dataIn;
        if (exp_idx == N-1) begin
          sb.push_back(model); exp_idx = 0; exp_full = 1'b1;
        end else exp_idx++;
      end
    end else if (outReady) exp_full = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    dataIn = d; dataValid = 1'b1; tick(); dataValid = 1'b0;
  endtask

  task automatic fill_vec(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) send(base + DW'(i));
  endtask

  task automatic pop_expected();
    if (sb.size() == 0) begin
      total++; $display("FAIL scoreboard_empty: no expected vector queued"); v = 'x;
    end else v = sb.pop_front();
  endtask

  task automatic release_vec();
    outReady = 1'b1; tick(); outReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    total++; if (dataReady !== 1'b0) $display("FAIL rst_ready_in_reset: got %b want 0", dataReady); else passed++;
    reset = 1'b0; #1;
    total++; if (dataReady !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", dataReady); else passed++;
    total++; if (outValid !== 1'b0) $display("FAIL rst_outvalid: got %b want 0", outValid); else passed++;
    total++; if (writeIndex !== '0) $display("FAIL rst_index: got %0d want 0", writeIndex); else passed++;
    total++; if (dataOut !== '0) $display("FAIL rst_dataout: got %h want 0", dataOut); else passed++;
  endtask

  task automatic test_basic_fill();
    for (int i = 1; i <= N; i++) begin
      total++; if (outValid !== 1'b0) $display("FAIL fill_early_valid: elem %0d got %b want 0", i, outValid); else passed++;
      send(DW'(i));
    end
    total++; if (outValid !== 1'b1) $display("FAIL fill_outvalid: got %b want 1", outValid); else passed++;
    total++; if (dataReady !== 1'b0) $display("FAIL fill_ready: got %b want 0", dataReady); else passed++;
    total++; if (dataOut[7:0] !== 8'h01) $display("FAIL fill_slot0: got %h want 01", dataOut[7:0]); else passed++;
    total++; if (dataOut[79:72] !== 8'h0A) $display("FAIL fill_slot9: got %h want 0a", dataOut[79:72]); else passed++;
    pop_expected();
    total++; if (dataOut !== v) $display("FAIL fill_vector: got %h want %h", dataOut, v); else passed++;
    release_vec();
    total++; if (outValid !== 1'b0) $display("FAIL fill_release: got %b want 0", outValid); else passed++;
  endtask

  task automatic test_backpressure();
    fill_vec(8'h20);
    pop_expected();
    outReady = 1'b0; dataValid = 1'b1; dataIn = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (dataOut !== v) $display("FAIL bp_hold c%0d: got %h want %h", c, dataOut, v); else passed++;
      total++; if (writeIndex !== '0) $display("FAIL bp_index c%0d: got %0d want 0", c, writeIndex); else passed++;
      total++; if (outValid !== 1'b1) $display("FAIL bp_valid c%0d: got %b want 1", c, outValid); else passed++;
    end
    outReady = 1'b1; tick(); outReady = 1'b0; dataValid = 1'b0;
    total++; if (outValid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", outValid); else passed++;
    total++; if (dataReady !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", dataReady); else passed++;
    total++; if (dataOut !== model) $display("FAIL bp_no_ff: got %h want %h", dataOut, model); else passed++;
  endtask

  task automatic test_gapped();
    for (int i = 0; i < N; i++) begin
      send(8'h30 + DW'(i));
      total++; if (outValid !== (i == N-1)) $display("FAIL gap_valid i%0d: got %b want %b", i, outValid, i == N-1); else passed++;
      tick();
      total++; if (writeIndex !== AW'((i + 1) % N)) $display("FAIL gap_index i%0d: got %0d want %0d", i, writeIndex, (i + 1) % N); else passed++;
    end
    pop_expected();
    total++; if (dataOut !== v) $display("FAIL gap_vector: got %h want %h", dataOut, v); else passed++;
    release_vec();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) send(8'h40 + DW'(i));
    flush = 1'b1; dataValid = 1'b1; dataIn = 8'h55; tick();
    flush = 1'b0; dataValid = 1'b0;
    total++; if (writeIndex !== '0) $display("FAIL flush_index: got %0d want 0", writeIndex); else passed++;
    total++; if (dataOut !== model) $display("FAIL flush_no_write: got %h want %h", dataOut, model); else passed++;
    fill_vec(8'h10);
    total++; if (dataOut[7:0] !== 8'h10) $display("FAIL flush_slot0: got %h want 10", dataOut[7:0]); else passed++;
    total++; if (dataOut[79:72] !== 8'h19) $display("FAIL flush_slot9: got %h want 19", dataOut[79:72]); else passed++;
    pop_expected();
    total++; if (dataOut !== v) $display("FAIL flush_vector: got %h want %h", dataOut, v); else passed++;
    release_vec();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) send(8'h50 + DW'(i));
    reset = 1'b1; tick(); reset = 1'b0; #1;
    total++; if (outValid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", outValid); else passed++;
    total++; if (writeIndex !== '0) $display("FAIL rmid_index: got %0d want 0", writeIndex); else passed++;
    total++; if (dataOut !== '0) $display("FAIL rmid_dataout: got %h want 0", dataOut); else passed++;
    fill_vec(8'h60);
    total++; if (outValid !== 1'b1) $display("FAIL rmid_refill_valid: got %b want 1", outValid); else passed++;
    pop_expected();
    total++; if (dataOut !== v) $display("FAIL rmid_refill_vector: got %h want %h", dataOut, v); else passed++;
    reset = 1'b1; tick(); reset = 1'b0; #1;
    total++; if (outValid !== 1'b0) $display("FAIL rfull_valid: got %b want 0", outValid); else passed++;
    total++; if (dataReady !== 1'b1) $display("FAIL rfull_ready: got %b want 1", dataReady); else passed++;
  endtask

  task automatic test_outready_only_exit();
    fill_vec(8'h70);
    pop_expected();
    flush = 1'b1; outReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (outValid !== 1'b1) $display("FAIL fullflush_valid c%0d: got %b want 1", c, outValid); else passed++;
      total++; if (dataReady !== 1'b0) $display("FAIL fullflush_ready c%0d: got %b want 0", c, dataReady); else passed++;
    end
    total++; if (dataOut !== v) $display("FAIL fullflush_vector: got %h want %h", dataOut, v); else passed++;
    flush = 1'b0; release_vec();
    total++; if (outValid !== 1'b0) $display("FAIL fullflush_exit: got %b want 0", outValid); else passed++;
  endtask

  task automatic test_back_to_back();
    outReady = 1'b1;
    fill_vec(8'h80);
    total++; if (outValid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", outValid); else passed++;
    pop_expected();
    total++; if (dataOut !== v) $display("FAIL b2b_vector1: got %h want %h", dataOut, v); else passed++;
    send(8'hAA);
    total++; if (outValid !== 1'b0) $display("FAIL b2b_exit: got %b want 0", outValid); else passed++;
    total++; if (writeIndex !== '0) $display("FAIL b2b_ignored_elem: got %0d want 0", writeIndex); else passed++;
    fill_vec(8'h90);
    pop_expected();
    total++; if (dataOut !== v) $display("FAIL b2b_vector2: got %h want %h", dataOut, v); else passed++;
    tick(); outReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_backpressure();
    test_gapped();
    test_flush();
    test_reset_mid();
    test_outready_only_exit();
    test_back_to_back();
    total++; if (sb.size() != 0) $display("FAIL sb_leftover: got %0d want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/layer_output_packer.md
LAYER_OUTPUT_PACKER -- requirements
Module: layer_output_packer

Interface
REQ-001 SHALL have parameter dataWidth, default 8, width of one neuron output element.
REQ-002 SHALL have parameter numOutputs, default 10, number of elements per packed vector.
REQ-003 SHALL have parameter addressWidth, default $clog2(numOutputs), width of the element index.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port dataIn  input  dataWidth  serial element from the producing layer.
REQ-007 SHALL have port dataValid  input  1  dataIn holds a valid element this cycle.
REQ-008 SHALL have port dataReady  output  1  the block accepts an element this cycle.
REQ-009 SHALL have port flush  input  1  abandons the partially filled vector.
REQ-010 SHALL have port outReady  input  1  the consumer has taken the packed vector.
REQ-011 SHALL have port dataOut  output  dataWidth*numOutputs  packed vector; element k at dataOut[k*dataWidth +: dataWidth].
REQ-012 SHALL have port outValid  output  1  dataOut holds a complete vector.
REQ-013 SHALL have port writeIndex  output  addressWidth  index the next accepted element will be written to.

Function
REQ-014 SHALL implement two states: FILL (collecting elements) and FULL (vector complete, held for consumer).
REQ-015 SHALL drive dataReady = 1 only in FILL with reset low; 0 in FULL and during reset.
REQ-016 SHALL accept an element on a cycle with dataValid && dataReady && !flush: write dataIn into slot writeIndex, all other slots unchanged.
REQ-017 SHALL increment writeIndex by 1 on each accepted element when writeIndex < numOutputs-1.
REQ-018 SHALL, on accepting the element with writeIndex == numOutputs-1, set writeIndex to 0, move to FULL and assert outValid in the next cycle (element-to-outValid latency 1 cycle).
REQ-019 SHALL hold outValid = 1 and dataOut stable throughout FULL; dataValid is ignored in FULL.
REQ-020 SHALL, in FULL with outReady = 1, deassert outValid and return to FILL next cycle; the first new element is accepted no earlier than that following cycle.
REQ-021 SHALL ignore outReady in FILL.
REQ-022 SHALL, in FILL with flush = 1, set writeIndex to 0 next cycle and discard any element presented that cycle (flush wins over dataValid); dataOut slots are not cleared.
REQ-023 SHALL ignore flush in FULL; outReady alone leaves FULL.
REQ-024 SHALL NOT clear dataOut on leaving FULL; slots are overwritten individually as new elements arrive, outValid gating validity.
REQ-025 SHALL never write outside slots 0..numOutputs-1, including when numOutputs is not a power of two.

Reset
REQ-026 SHALL, while reset is high, set state FILL, writeIndex 0, outValid 0, dataOut all zeros, and drop any element presented.
REQ-027 SHALL, on reset mid-fill or in FULL, abandon the vector with no outValid pulse; dataReady = 1 in the first cycle after reset deasserts.

Verification
REQ-028 SHALL verify basic fill: reset, then ten consecutive elements 0x01..0x0A with dataValid = 1 -> outValid = 1 one cycle after the tenth, dataOut[7:0] = 0x01, dataOut[79:72] = 0x0A, dataReady = 0.
REQ-029 SHALL verify backpressure: vector complete, outReady = 0 for 5 cycles while dataValid = 1 with 0xFF -> dataOut unchanged, writeIndex = 0; outReady = 1 -> outValid = 0 and dataReady = 1 next cycle.
REQ-030 SHALL verify gapped input: elements accepted only on alternating cycles -> writeIndex advances only on accepted cycles; outValid after the tenth element exactly.
REQ-031 SHALL verify flush: 4 elements accepted, then flush = 1 with dataValid = 1, data 0x55 -> writeIndex = 0, 0x55 not written; next 10 elements 0x10..0x19 give slot 0 = 0x10, slot 9 = 0x19.
REQ-032 SHALL verify reset mid-operation: reset after 6 elements -> outValid = 0, writeIndex = 0, dataOut = 0; a full 10-element refill then completes normally.
REQ-033 SHALL verify outReady-only exit: flush = 1 held in FULL with outReady = 0 -> outValid stays 1, state remains FULL.
